// File: rtl/video_pkg.sv
// Shared definitions for the video zone statistics block:
// colour width, BT.601-style luma coefficients and frame FSM states.
package video_pkg;

    localparam int COLOR_W = 8;

    // Y = (77*R + 150*G + 29*B) >> 8, coefficients sum to 256
    localparam int LUMA_R = 77;
    localparam int LUMA_G = 150;
    localparam int LUMA_B = 29;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN
    } state_t;

endpackage

// File: rtl/rgb2luma_pipe.sv
// Two-stage RGB888 to 8-bit luma pipeline with matching VS/DE delay.
// Ports: clk_i/rst_i (async, active-high), vs_i/de_i/r_i/g_i/b_i in,
// y_o/vs_o/de_o out, all delayed by exactly two clocks.
module rgb2luma_pipe
    import video_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               vs_i,
    input  logic               de_i,
    input  logic [COLOR_W-1:0] r_i,
    input  logic [COLOR_W-1:0] g_i,
    input  logic [COLOR_W-1:0] b_i,
    output logic [COLOR_W-1:0] y_o,
    output logic               vs_o,
    output logic               de_o
);

    localparam int PW = 2 * COLOR_W;

    logic [PW-1:0]      pr_q;
    logic [PW-1:0]      pg_q;
    logic [PW-1:0]      pb_q;
    logic               vs1_q;
    logic               de1_q;
    logic [COLOR_W-1:0] y_q;
    logic               vs2_q;
    logic               de2_q;
    logic [PW-1:0]      sum;

    // Max weighted sum is 255*256 = 65280, so PW bits never overflow
    assign sum = pr_q + pg_q + pb_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pr_q  <= '0;
            pg_q  <= '0;
            pb_q  <= '0;
            vs1_q <= 1'b0;
            de1_q <= 1'b0;
            y_q   <= '0;
            vs2_q <= 1'b0;
            de2_q <= 1'b0;
        end else begin
            pr_q  <= PW'(r_i) * PW'(LUMA_R);
            pg_q  <= PW'(g_i) * PW'(LUMA_G);
            pb_q  <= PW'(b_i) * PW'(LUMA_B);
            vs1_q <= vs_i;
            de1_q <= de_i;
            y_q   <= COLOR_W'(sum >> COLOR_W);
            vs2_q <= vs1_q;
            de2_q <= de1_q;
        end
    end

    assign y_o  = y_q;
    assign vs_o = vs2_q;
    assign de_o = de2_q;

endmodule

// File: rtl/video_zone_stats.sv
// Per-frame zone brightness (peak or mean luma) for MiniLED local dimming.
// Ports: I_pix_clk, I_rst (async high), I_vs/I_hs/I_de, I_data_r/g/b,
// I_mode (0 peak, 1 mean); O_zone_flat (zone 0 in [7:0]), O_frame_done, O_line_err.
module video_zone_stats
    import video_pkg::*;
#(
    parameter int H_ACTIVE  = 1024,
    parameter int ZONES     = 7,
    parameter int ZONE_W    = 146,
    parameter int ACC_W     = 32,
    parameter int AVG_SHIFT = 17,
    parameter bit VS_POL    = 1'b1
) (
    input  logic                     I_pix_clk,
    input  logic                     I_rst,
    input  logic                     I_vs,
    input  logic                     I_hs,
    input  logic                     I_de,
    input  logic [COLOR_W-1:0]       I_data_r,
    input  logic [COLOR_W-1:0]       I_data_g,
    input  logic [COLOR_W-1:0]       I_data_b,
    input  logic                     I_mode,
    output logic [ZONES*COLOR_W-1:0] O_zone_flat,
    output logic                     O_frame_done,
    output logic                     O_line_err
);

    localparam int XW = $clog2(H_ACTIVE + 1) + 1;
    localparam int ZW = $clog2(ZONE_W + 1);
    localparam int IW = (ZONES > 1) ? $clog2(ZONES) : 1;

    logic               unused_hs;
    logic [COLOR_W-1:0] y_d2;
    logic               vs_d2;
    logic               de_d2;

    assign unused_hs = I_hs;

    rgb2luma_pipe u_luma (
        .clk_i (I_pix_clk),
        .rst_i (I_rst),
        .vs_i  (I_vs),
        .de_i  (I_de),
        .r_i   (I_data_r),
        .g_i   (I_data_g),
        .b_i   (I_data_b),
        .y_o   (y_d2),
        .vs_o  (vs_d2),
        .de_o  (de_d2)
    );

    state_t             state_q, state_d;
    logic               vs_prev_q;
    logic               de_prev_q;
    logic [XW-1:0]      x_cnt_q, x_cnt_d;
    logic [ZW-1:0]      zcnt_q, zcnt_d;
    logic [IW-1:0]      zidx_q, zidx_d;
    logic               sticky_q, sticky_d;
    logic               mode_lat_q, mode_lat_d;
    logic [COLOR_W-1:0] zmax_q [ZONES];
    logic [COLOR_W-1:0] zmax_d [ZONES];
    logic [ACC_W-1:0]   zsum_q [ZONES];
    logic [ACC_W-1:0]   zsum_d [ZONES];
    logic [COLOR_W-1:0] zmean  [ZONES];
    logic [COLOR_W-1:0] res_q  [ZONES];
    logic               lerr_lat_q;
    logic               upd_q;
    logic [ZONES*COLOR_W-1:0] flat_q;
    logic               done_q;
    logic               lerr_q;

    logic               vs_act;
    logic               vs_edge;
    logic               de_fall;
    logic               bad_line;
    logic               arm;
    logic               fend;
    logic               clr;
    logic [ACC_W:0]     sum_ext;

    assign vs_act   = (vs_d2 == VS_POL);
    assign vs_edge  = vs_act & ~vs_prev_q;
    assign de_fall  = de_prev_q & ~de_d2;
    assign bad_line = de_fall & (x_cnt_q != XW'(H_ACTIVE));
    assign clr      = arm | fend;

    // Frame FSM: the first VS edge after reset only arms (partial frame
    // discarded); every later edge closes a frame.
    always_ff @(posedge I_pix_clk or posedge I_rst) begin
        if (I_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        arm     = 1'b0;
        fend    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (vs_edge) begin
                    state_d = ARMED;
                    arm     = 1'b1;
                end
            end
            ARMED, RUN: begin
                if (vs_edge) begin
                    state_d = RUN;
                    fend    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar k = 0; k < ZONES; k++) begin : g_mean
        logic [ACC_W-1:0] sh;
        assign sh       = zsum_q[k] >> AVG_SHIFT;
        assign zmean[k] = (sh > ACC_W'(255)) ? '1 : sh[COLOR_W-1:0];
    end

    // Counting and accumulation. The clear is applied first so a pixel
    // coinciding with the frame edge lands in the new frame.
    always_comb begin
        x_cnt_d    = x_cnt_q;
        zcnt_d     = zcnt_q;
        zidx_d     = zidx_q;
        zmax_d     = zmax_q;
        zsum_d     = zsum_q;
        sum_ext    = '0;
        sticky_d   = clr ? 1'b0 : (sticky_q | bad_line);
        mode_lat_d = clr ? I_mode : mode_lat_q;

        if (clr) begin
            for (int k = 0; k < ZONES; k++) begin
                zmax_d[k] = '0;
                zsum_d[k] = '0;
            end
        end

        if (de_fall) begin
            x_cnt_d = '0;
            zcnt_d  = '0;
            zidx_d  = '0;
        end

        if (de_d2) begin
            if (x_cnt_q != '1) x_cnt_d = x_cnt_q + XW'(1);
            if (y_d2 > zmax_d[zidx_q]) zmax_d[zidx_q] = y_d2;
            sum_ext = {1'b0, zsum_d[zidx_q]} + (ACC_W + 1)'(y_d2);
            zsum_d[zidx_q] = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
            // Last zone holds its index and absorbs the line remainder
            if (zidx_q != IW'(ZONES - 1)) begin
                if (zcnt_q == ZW'(ZONE_W - 1)) begin
                    zidx_d = zidx_q + IW'(1);
                    zcnt_d = '0;
                end else begin
                    zcnt_d = zcnt_q + ZW'(1);
                end
            end
        end
    end

    always_ff @(posedge I_pix_clk or posedge I_rst) begin
        if (I_rst) begin
            vs_prev_q  <= 1'b0;
            de_prev_q  <= 1'b0;
            x_cnt_q    <= '0;
            zcnt_q     <= '0;
            zidx_q     <= '0;
            sticky_q   <= 1'b0;
            mode_lat_q <= 1'b0;
            lerr_lat_q <= 1'b0;
            upd_q      <= 1'b0;
            flat_q     <= '0;
            done_q     <= 1'b0;
            lerr_q     <= 1'b0;
            for (int k = 0; k < ZONES; k++) begin
                zmax_q[k] <= '0;
                zsum_q[k] <= '0;
                res_q[k]  <= '0;
            end
        end else begin
            vs_prev_q  <= vs_act;
            de_prev_q  <= de_d2;
            x_cnt_q    <= x_cnt_d;
            zcnt_q     <= zcnt_d;
            zidx_q     <= zidx_d;
            sticky_q   <= sticky_d;
            mode_lat_q <= mode_lat_d;
            zmax_q     <= zmax_d;
            zsum_q     <= zsum_d;
            upd_q      <= fend;
            done_q     <= upd_q;
            if (fend) begin
                lerr_lat_q <= sticky_q | bad_line;
                for (int k = 0; k < ZONES; k++) begin
                    res_q[k] <= mode_lat_q ? zmean[k] : zmax_q[k];
                end
            end
            if (upd_q) begin
                lerr_q <= lerr_lat_q;
                for (int k = 0; k < ZONES; k++) begin
                    flat_q[k*COLOR_W +: COLOR_W] <= res_q[k];
                end
            end
        end
    end

    assign O_zone_flat  = flat_q;
    assign O_frame_done = done_q;
    assign O_line_err   = lerr_q;

endmodule

// File: tb/tb_video_zone_stats.sv
// Directed bench for video_zone_stats: small 4x14 frames, 7 zones of 2 px.
// Results of a frame appear after the VS that starts the following frame.
module tb_video_zone_stats;

    localparam int HA = 14;
    localparam int NZ = 7;
    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          vs, hs, de, mode;
    logic [7:0]    r, g, b;
    logic [NZ*8-1:0] flat;
    logic          done, lerr;

    always #5 clk = ~clk;

    video_zone_stats #(
        .H_ACTIVE(HA), .ZONES(NZ), .ZONE_W(2),
        .ACC_W(32), .AVG_SHIFT(3), .VS_POL(1'b1)
    ) dut (
        .I_pix_clk(clk), .I_rst(rst), .I_vs(vs), .I_hs(hs), .I_de(de),
        .I_data_r(r), .I_data_g(g), .I_data_b(b), .I_mode(mode),
        .O_zone_flat(flat), .O_frame_done(done), .O_line_err(lerr)
    );

    logic [23:0] fr [NL][HA];
    int          checks = 0;
    int          passes = 0;
    int          done_cnt = 0;
    int          wide = 0;
    int          d0;
    logic        prev_done = 1'b0;
    logic [55:0] cap_flat = '0;
    logic        cap_lerr = 1'b0;

    always @(negedge clk) begin
        if (done) begin
            done_cnt = done_cnt + 1;
            cap_flat = flat;
            cap_lerr = lerr;
            if (prev_done) wide = wide + 1;
        end
        prev_done = done;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] zf(input int a0, a1, a2, a3,
                                       input int a4, a5, a6);
        return {8'h00, a6[7:0], a5[7:0], a4[7:0], a3[7:0],
                a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    function automatic logic [63:0] uni(input int v);
        return zf(v, v, v, v, v, v, v);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_uni(input logic [23:0] c);
        for (int l = 0; l < NL; l++)
            for (int p = 0; p < HA; p++) fr[l][p] = c;
    endtask

    task automatic fill_gray_zone;
        int z;
        for (int l = 0; l < NL; l++)
            for (int p = 0; p < HA; p++) begin
                z = (p / 2 > 6) ? 6 : p / 2;
                fr[l][p] = {3{8'(10 * z)}};
            end
    endtask

    task automatic fill_single;
        fill_uni(24'h0);
        fr[1][6] = {3{8'd200}};
    endtask

    task automatic run_frame(input bit m, input int nlines,
                             input bit de_en, input bit short);
        mode = m;
        vs = 1'b1;
        tick; tick;
        vs = 1'b0;
        tick; tick; tick;
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < HA; p++) begin
                de = de_en && !(short && l == 2 && p == HA - 1);
                {r, g, b} = de ? fr[l][p] : 24'h0;
                tick;
            end
            de = 1'b0;
            {r, g, b} = 24'h0;
            hs = 1'b1;
            tick; tick;
            hs = 1'b0;
            tick; tick;
        end
        tick; tick;
    endtask

    initial begin
        rst = 1'b1;
        vs = 1'b0; hs = 1'b0; de = 1'b0; mode = 1'b0;
        r = 8'h0; g = 8'h0; b = 8'h0;
        tick; tick;
        check("reset_flat", {8'h0, flat}, 64'h0);
        check("reset_done", {63'h0, done}, 64'h0);
        check("reset_lerr", {63'h0, lerr}, 64'h0);
        rst = 1'b0;
        tick;

        // First VS only arms
        fill_uni(24'hFFFFFF);
        run_frame(1'b1, NL, 1'b1, 1'b0);
        check("arm_no_done", 64'(done_cnt), 64'd0);
        check("arm_flat", {8'h0, flat}, 64'h0);

        d0 = done_cnt;
        fill_uni(24'hFF0000);
        run_frame(1'b1, NL, 1'b1, 1'b0);
        check("white_done", 64'(done_cnt - d0), 64'd1);
        check("white_mean", {8'h0, cap_flat}, uni(255));
        check("white_lerr", {63'h0, cap_lerr}, 64'h0);
        check("hold_flat", {8'h0, flat}, uni(255));

        fill_uni(24'h00FF00);
        run_frame(1'b1, NL, 1'b1, 1'b0);
        check("red_mean", {8'h0, cap_flat}, uni(76));

        fill_uni(24'h0000FF);
        run_frame(1'b1, NL, 1'b1, 1'b0);
        check("green_mean", {8'h0, cap_flat}, uni(149));

        fill_gray_zone();
        run_frame(1'b1, NL, 1'b1, 1'b0);
        check("blue_mean", {8'h0, cap_flat}, uni(28));

        fill_single();
        run_frame(1'b0, NL, 1'b1, 1'b0);
        check("gray_ramp", {8'h0, cap_flat}, zf(0, 10, 20, 30, 40, 50, 60));

        run_frame(1'b1, NL, 1'b1, 1'b0);
        check("single_peak", {8'h0, cap_flat}, zf(0, 0, 0, 200, 0, 0, 0));

        fill_uni(24'hFFFFFF);
        run_frame(1'b1, NL, 1'b1, 1'b1);
        check("single_mean", {8'h0, cap_flat}, zf(0, 0, 0, 25, 0, 0, 0));
        check("clean_lerr", {63'h0, cap_lerr}, 64'h0);

        fill_gray_zone();
        run_frame(1'b1, NL, 1'b1, 1'b0);
        check("short_mean", {8'h0, cap_flat},
              zf(255, 255, 255, 255, 255, 255, 223));
        check("short_lerr", {63'h0, cap_lerr}, 64'h1);
        check("short_lerr_out", {63'h0, lerr}, 64'h1);

        run_frame(1'b1, NL, 1'b0, 1'b0);
        check("after_short_lerr", {63'h0, cap_lerr}, 64'h0);
        check("after_short_ramp", {8'h0, cap_flat},
              zf(0, 10, 20, 30, 40, 50, 60));

        fill_uni(24'hFFFFFF);
        run_frame(1'b0, NL, 1'b1, 1'b0);
        check("no_de_zero", {8'h0, cap_flat}, 64'h0);

        d0 = done_cnt;
        fill_gray_zone();
        run_frame(1'b0, 2, 1'b1, 1'b0);
        check("pre_rst_peak", {8'h0, cap_flat}, uni(255));
        check("pre_rst_done", 64'(done_cnt - d0), 64'd1);

        rst = 1'b1;
        #1;
        check("midrst_flat", {8'h0, flat}, 64'h0);
        check("midrst_done", {63'h0, done}, 64'h0);
        check("midrst_lerr", {63'h0, lerr}, 64'h0);
        tick; tick;
        rst = 1'b0;
        tick;

        d0 = done_cnt;
        fill_uni(24'hFFFFFF);
        run_frame(1'b1, NL, 1'b1, 1'b0);
        check("post_rst_discard", 64'(done_cnt - d0), 64'd0);
        check("post_rst_flat", {8'h0, flat}, 64'h0);

        fill_uni(24'hFF0000);
        run_frame(1'b1, NL, 1'b1, 1'b0);
        check("post_rst_done", 64'(done_cnt - d0), 64'd1);
        check("post_rst_white", {8'h0, cap_flat}, uni(255));

        run_frame(1'b1, NL, 1'b0, 1'b0);
        check("post_rst_red", {8'h0, cap_flat}, uni(76));
        check("done_width", 64'(wide), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
